// File: rtl/z_core_alu_iter_pkg.sv
// z_core_alu_iter_pkg: shared ALU op codes, FSM state encodings and op helpers
package z_core_alu_iter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;
  function automatic logic is_shift(input logic [3:0] t);
    return t == ALU_SLL || t == ALU_SRL || t == ALU_SRA;
  endfunction
endpackage

// File: rtl/z_core_alu_iter_shift_step.sv
// z_core_shift_step: one-bit combinational shift
// ports: value in, right (1 = shift right), arith (fill with value msb on right shift), shifted out
module z_core_shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             right,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted
);
  assign shifted = right ? {arith & value[WIDTH-1], value[WIDTH-1:1]} : {value[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/z_core_alu_iter.sv
// z_core_alu_iter: single-issue ALU with bit-serial shifter and valid/ready handshakes
// ports: clk, rst (async, active-high); in_valid/in_ready + alu_inst_type/op_a/op_b request;
//        out_valid/out_ready + result/illegal registered response
module z_core_alu_iter
  import z_core_alu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_inst_type,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  state_e state, state_n;
  logic [4:0] cnt;
  logic [4:0] sh;
  logic right, arith, accept, alu_ill, long_shift;
  logic [XLEN-1:0] alu_res, step;
  assign sh = op_b[4:0];
  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign accept = in_valid && in_ready;
  assign long_shift = is_shift(alu_inst_type) && sh != 5'd0;
  // shifts load op_a unchanged; the serial shifter then works on the result register
  always_comb begin
    alu_ill = alu_inst_type > 4'd9;
    alu_res = alu_inst_type == ALU_ADD  ? op_a + op_b :
              alu_inst_type == ALU_SUB  ? op_a - op_b :
              alu_inst_type == ALU_SLT  ? {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)} :
              alu_inst_type == ALU_SLTU ? {{(XLEN-1){1'b0}}, op_a < op_b} :
              alu_inst_type == ALU_XOR  ? op_a ^ op_b :
              alu_inst_type == ALU_OR   ? op_a | op_b :
              alu_inst_type == ALU_AND  ? op_a & op_b :
              is_shift(alu_inst_type)   ? op_a : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = accept ? (long_shift ? S_SHIFT : S_DONE) : S_IDLE;
      S_SHIFT: state_n = cnt == 5'd1 ? S_DONE : S_SHIFT;
      S_DONE:  state_n = out_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      illegal <= 1'b0;
      cnt <= 5'd0;
      right <= 1'b0;
      arith <= 1'b0;
    end else if (accept) begin
      result <= alu_res;
      illegal <= alu_ill;
      cnt <= is_shift(alu_inst_type) ? sh : 5'd0;
      right <= alu_inst_type != ALU_SLL;
      arith <= alu_inst_type == ALU_SRA;
    end else if (state == S_SHIFT) begin
      result <= step;
      cnt <= cnt - 5'd1;
    end
  end
  z_core_shift_step #(.WIDTH(XLEN)) u_step (
    .value  (result),
    .right  (right),
    .arith  (arith),
    .shifted(step)
  );
endmodule
